conv_window_scheduler: RTL
==========================

Name: conv_window_scheduler

Overview:
Sequences the conv_buffer line buffer for one frame at a time.
- Accepts a raster pixel stream through a valid/ready handshake and forwards it to the buffer's in_point/valid_in/frame_column_size.
- Tracks each pixel's row/column position and qualifies the buffer's out_matrix with win_valid only for legal, stride-aligned windows.
- Signals frame completion and rejects illegal configurations.

Parameters:
- DATA_WIDTH, 8, pixel width.
- BUFFER_LENGTH, 2000, max frame columns supported by conv_buffer.
- KERNEL_ROW_SIZE, 3, kernel rows.
- KERNEL_COLUMN_SIZE, 3, kernel columns.
- MAX_ROWS, 2048, max frame rows.
- BUF_LATENCY, 1, cycles from buf_valid high to out_matrix reflecting that pixel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse: latch config and begin a frame (honoured in IDLE only).
- cfg_cols  in  $clog2(BUFFER_LENGTH)  frame columns.
- cfg_rows  in  $clog2(MAX_ROWS)  frame rows.
- cfg_stride  in  2  window stride; legal values 1..3.
- s_data  in  DATA_WIDTH  input pixel.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  scheduler accepts a pixel.
- buf_point  out  DATA_WIDTH  to conv_buffer in_point.
- buf_valid  out  1  to conv_buffer valid_in.
- buf_col_size  out  $clog2(BUFFER_LENGTH)  to conv_buffer frame_column_size.
- win_valid  out  1  out_matrix holds a legal window this cycle.
- win_row  out  $clog2(MAX_ROWS)  output-map row of the current window.
- win_col  out  $clog2(BUFFER_LENGTH)  output-map column of the current window.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse when a config is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts immediately; the next frame needs a new cfg_start.
- States:
  - IDLE -> RUN on cfg_start with legal config.
  - RUN -> FLUSH when the last pixel (rows*cols) is accepted.
  - FLUSH -> DONE after BUF_LATENCY+1 cycles.
  - DONE -> IDLE after 1 cycle; frame_done=1 in DONE.
- Legal config: KERNEL_COLUMN_SIZE <= cfg_cols <= BUFFER_LENGTH, KERNEL_ROW_SIZE <= cfg_rows <= MAX_ROWS, cfg_stride != 0.
  - Illegal: cfg_err=1 on the next cycle; stay IDLE.
  - Config is latched at start. buf_col_size holds the latched cfg_cols from start until the next start.
- s_ready = 1 only in RUN. A pixel is accepted when s_valid && s_ready.
- Accepted pixel: buf_point/buf_valid registered, 1 cycle later. buf_valid=0 on cycles with no acceptance; gaps are allowed.
- Position counters (r,c) advance per accepted pixel; c wraps at cols-1, and r increments on wrap.
- Window legality, evaluated for each accepted pixel, all three conditions required:
  - r >= KERNEL_ROW_SIZE-1
  - c >= KERNEL_COLUMN_SIZE-1
  - row and column stride phase counters both 0. Phase counters reset at r=KR-1 / c=KC-1 and count modulo stride; no divider.
- win_valid is asserted BUF_LATENCY cycles after the matching buf_valid, through a delay pipe. win_row/win_col are carried through the same pipe.
- win_col starts at 0 per row and increments per legal column window. win_row increments after each row that produced windows.
- Windows per frame: ((rows-KR)/stride+1) * ((cols-KC)/stride+1).
- cfg_start during RUN/FLUSH/DONE is ignored and produces no cfg_err.
- In FLUSH no pixels are accepted; win_valid may still fire for pipelined windows.
- busy = 1 in RUN and FLUSH.

Optional Feature:
- Macro CONV_SCHED_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits), cleared on cfg_start. It increments every RUN cycle with s_valid=0 and saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Package conv_sched_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - stride width constant
  - legality helper function
- Sub-module conv_pos_counter: row/col counters plus stride phase counters; outputs r, c, last_pixel, window_legal.

Test Plan:
- 6x6 frame, stride 1, pixels 1..36 continuous -> 16 win_valid pulses. First pulse aligned with pixel 15 (r=2,c=2) with win_row=0,win_col=0; last pulse win_row=3,win_col=3; frame_done one cycle after FLUSH ends.
- 6x6 frame, stride 2 -> exactly 4 windows, at pixels (2,2),(2,4),(4,2),(4,4), indices (0,0),(0,1),(1,0),(1,1).
- 6x6 frame, stride 1, s_valid low every other cycle -> same 16 windows and coordinates; buf_valid only on accepted cycles.
- cfg_cols=2, cfg_stride=0, and cfg_rows=1, each tried separately -> cfg_err pulse, s_ready stays 0, busy=0.
- rst=1 after pixel 20 of a 6x6 frame -> next cycle all outputs 0, IDLE. A fresh 5x5 stride-1 frame then yields 9 windows.
- cfg_start pulsed mid-frame -> ignored; frame completes with 16 windows and no cfg_err.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv_buffer window scheduler.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int STRIDE_W = 2;

    // A frame must fit at least one kernel and stay inside buffer/row limits.
    function automatic logic cfg_legal(
        input int unsigned cols,
        input int unsigned rows,
        input int unsigned stride,
        input int unsigned kc,
        input int unsigned kr,
        input int unsigned max_cols,
        input int unsigned max_rows
    );
        return (cols >= kc) && (cols <= max_cols) &&
               (rows >= kr) && (rows <= max_rows) &&
               (stride != 0);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position tracker: row/column counters plus stride phase counters
// that mark which pixels complete a stride-aligned kernel window.
module conv_pos_counter
    import conv_sched_pkg::*;
#(
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3,
    parameter int RW                 = 11,
    parameter int CW                 = 11
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    input  logic [CW-1:0]       cols,
    input  logic [RW-1:0]       rows,
    input  logic [STRIDE_W-1:0] stride,
    output logic [RW-1:0]       r,
    output logic [CW-1:0]       c,
    output logic                row_phase_zero,
    output logic                last_pixel,
    output logic                window_legal
);
    localparam logic [RW-1:0] R_FIRST = RW'(KERNEL_ROW_SIZE - 1);
    localparam logic [CW-1:0] C_FIRST = CW'(KERNEL_COLUMN_SIZE - 1);

    logic [RW-1:0]       r_reg;
    logic [CW-1:0]       c_reg;
    logic [STRIDE_W-1:0] row_phase_reg;
    logic [STRIDE_W-1:0] col_phase_reg;
    logic                row_end;

    assign r              = r_reg;
    assign c              = c_reg;
    assign row_end        = (c_reg == cols - CW'(1));
    assign last_pixel     = row_end && (r_reg == rows - RW'(1));
    assign row_phase_zero = (row_phase_reg == '0);
    assign window_legal   = (r_reg >= R_FIRST) && (c_reg >= C_FIRST) &&
                            row_phase_zero && (col_phase_reg == '0);

    // Phases are held at 0 until the first full-kernel position, then count modulo stride.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_reg         <= '0;
            c_reg         <= '0;
            row_phase_reg <= '0;
            col_phase_reg <= '0;
        end else if (advance) begin
            if (row_end) begin
                c_reg         <= '0;
                col_phase_reg <= '0;
                r_reg         <= r_reg + RW'(1);
                if (r_reg < R_FIRST || row_phase_reg == stride - STRIDE_W'(1))
                    row_phase_reg <= '0;
                else
                    row_phase_reg <= row_phase_reg + STRIDE_W'(1);
            end else begin
                c_reg <= c_reg + CW'(1);
                if (c_reg < C_FIRST || col_phase_reg == stride - STRIDE_W'(1))
                    col_phase_reg <= '0;
                else
                    col_phase_reg <= col_phase_reg + STRIDE_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Per-frame sequencer for the conv_buffer line buffer: forwards pixels and flags legal windows.
// Build option CONV_SCHED_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int BUFFER_LENGTH      = 2000,
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3,
    parameter int MAX_ROWS           = 2048,
    parameter int BUF_LATENCY        = 1
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] cfg_cols,
    input  logic [$clog2(MAX_ROWS)-1:0]      cfg_rows,
    input  logic [STRIDE_W-1:0]              cfg_stride,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            buf_point,
    output logic                             buf_valid,
    output logic [$clog2(BUFFER_LENGTH)-1:0] buf_col_size,
    output logic                             win_valid,
    output logic [$clog2(MAX_ROWS)-1:0]      win_row,
    output logic [$clog2(BUFFER_LENGTH)-1:0] win_col,
    output logic                             busy,
    output logic                             frame_done,
`ifdef CONV_SCHED_STALL_CNT_EN
    output logic [31:0]                      stall_cnt,
`endif
    output logic                             cfg_err
);
    localparam int CW = $clog2(BUFFER_LENGTH);
    localparam int RW = $clog2(MAX_ROWS);
    localparam int FW = $clog2(BUF_LATENCY + 2);
    localparam logic [RW-1:0] R_FIRST = RW'(KERNEL_ROW_SIZE - 1);

    sched_state_t        state_reg, state_next;
    logic [FW-1:0]       flush_cnt_reg;
    logic [CW-1:0]       cols_reg;
    logic [RW-1:0]       rows_reg;
    logic [STRIDE_W-1:0] stride_reg;
    logic [RW-1:0]       out_row_reg;
    logic [CW-1:0]       out_col_reg;
    logic [DATA_WIDTH-1:0] buf_point_reg;
    logic                buf_valid_reg;
    logic                cfg_err_reg;
    logic                win_v_pipe   [0:BUF_LATENCY];
    logic [RW-1:0]       win_row_pipe [0:BUF_LATENCY];
    logic [CW-1:0]       win_col_pipe [0:BUF_LATENCY];

    logic          cfg_ok, start_ok, start_bad, accept, emit;
    logic [RW-1:0] pos_r;
    logic [CW-1:0] pos_c;
    logic          row_phase_zero, last_pixel, window_legal, row_end, row_has_windows;

    assign cfg_ok    = cfg_legal(32'(cfg_cols), 32'(cfg_rows), 32'(cfg_stride),
                                 KERNEL_COLUMN_SIZE, KERNEL_ROW_SIZE, BUFFER_LENGTH, MAX_ROWS);
    assign start_ok  = (state_reg == IDLE) && cfg_start && cfg_ok;
    assign start_bad = (state_reg == IDLE) && cfg_start && !cfg_ok;
    assign accept    = s_valid && (state_reg == RUN);
    assign emit      = accept && window_legal;
    assign row_end   = (pos_c == cols_reg - CW'(1));
    assign row_has_windows = (pos_r >= R_FIRST) && row_phase_zero;

    conv_pos_counter #(
        .KERNEL_ROW_SIZE    (KERNEL_ROW_SIZE),
        .KERNEL_COLUMN_SIZE (KERNEL_COLUMN_SIZE),
        .RW                 (RW),
        .CW                 (CW)
    ) u_pos (
        .clk            (clk),
        .rst            (rst),
        .clear          (start_ok),
        .advance        (accept),
        .cols           (cols_reg),
        .rows           (rows_reg),
        .stride         (stride_reg),
        .r              (pos_r),
        .c              (pos_c),
        .row_phase_zero (row_phase_zero),
        .last_pixel     (last_pixel),
        .window_legal   (window_legal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (accept && last_pixel) state_next = FLUSH;
            FLUSH:   if (flush_cnt_reg == FW'(BUF_LATENCY)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
            cols_reg      <= '0;
            rows_reg      <= '0;
            stride_reg    <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= (state_reg == FLUSH) ? flush_cnt_reg + FW'(1) : '0;
            cfg_err_reg   <= start_bad;
            if (start_ok) begin
                cols_reg   <= cfg_cols;
                rows_reg   <= cfg_rows;
                stride_reg <= cfg_stride;
            end
        end
    end

    // Output-map indices: column restarts each row, row advances only after rows that emitted windows.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            out_row_reg <= '0;
            out_col_reg <= '0;
        end else if (accept) begin
            if (row_end) begin
                out_col_reg <= '0;
                if (row_has_windows) out_row_reg <= out_row_reg + RW'(1);
            end else if (window_legal) begin
                out_col_reg <= out_col_reg + CW'(1);
            end
        end
    end

    // Stage 0 lines up with buf_valid; the last stage lines up with out_matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_point_reg <= '0;
            for (int i = 0; i <= BUF_LATENCY; i++) begin
                win_v_pipe[i]   <= 1'b0;
                win_row_pipe[i] <= '0;
                win_col_pipe[i] <= '0;
            end
        end else begin
            buf_valid_reg <= accept;
            if (accept) buf_point_reg <= s_data;
            win_v_pipe[0] <= emit;
            if (emit) begin
                win_row_pipe[0] <= out_row_reg;
                win_col_pipe[0] <= out_col_reg;
            end
            for (int i = 1; i <= BUF_LATENCY; i++) begin
                win_v_pipe[i]   <= win_v_pipe[i-1];
                win_row_pipe[i] <= win_row_pipe[i-1];
                win_col_pipe[i] <= win_col_pipe[i-1];
            end
        end
    end

`ifdef CONV_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (cfg_start && state_reg == IDLE) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == RUN && !s_valid && stall_cnt_reg != '1) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end
    assign stall_cnt = stall_cnt_reg;
`endif

    assign s_ready      = (state_reg == RUN);
    assign busy         = (state_reg == RUN) || (state_reg == FLUSH);
    assign frame_done   = (state_reg == DONE);
    assign cfg_err      = cfg_err_reg;
    assign buf_point    = buf_point_reg;
    assign buf_valid    = buf_valid_reg;
    assign buf_col_size = cols_reg;
    assign win_valid    = win_v_pipe[BUF_LATENCY];
    assign win_row      = win_row_pipe[BUF_LATENCY];
    assign win_col      = win_col_pipe[BUF_LATENCY];

endmodule
